rv32im_exu_sequencer: RTL and testbench
=======================================

# rv32im_exu_sequencer

Multi-cycle sequencer wrapped around the combinational `rv32im_exu`. It accepts one decoded instruction at a time from the decoder and holds the EXU operands stable while the instruction executes. It runs the data-memory handshake for loads and stores, starts and waits on the multi-cycle MDU for mul/div, and then issues a one-cycle commit. The commit carries register write-back, PC update and retire count. Bus and MDU timeouts park the sequencer in a fault state until the core flushes it.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum number of wait cycles allowed in MEM_REQ, MEM_WAIT or MDU_WAIT before a fault is raised. Legal range is 1..65535.
- `clk_i` in 1: the single clock, rising-edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `issue_valid_i` in 1: a decoded instruction is presented.
- `issue_ready_o` out 1: the sequencer accepts an instruction this cycle. Combinational, equal to (state == IDLE).
- `is_load_i`, `is_store_i`, `is_mdu_i`, `rd_write_i` in 1 each: instruction class flags, sampled on acceptance.
- `exu_memaddr_i`, `exu_memdatawr_i` in `API_DATA_WIDTH`: memory address and store data from the EXU, sampled on acceptance.
- `mem_req_o` out 1: bus request.
- `mem_we_o` out 1: 1 for a store.
- `mem_addr_o`, `mem_wdata_o` out `API_DATA_WIDTH`: registered bus address and store data.
- `mem_gnt_i`, `mem_rvalid_i`, `mem_err_i` in 1: bus grant, response valid, and bus error (qualified by `mem_rvalid_i`).
- `mem_rdata_i` in `API_DATA_WIDTH`: load response data.
- `memdatard_o` out `API_DATA_WIDTH`: registered load data, connected to the EXU `val_memdatard_i`.
- `mdu_start_o` out 1: one-cycle start pulse to the MDU.
- `mdu_done_i` in 1: MDU result valid.
- `wb_en_o` out 1: register-file write strobe.
- `pc_update_o` out 1: commit strobe, which loads the EXU `new_pc_o`.
- `stall_o` out 1: high whenever state is not IDLE.
- `flush_i` in 1: synchronous abort request.
- `fault_o` out 1: high while in FAULT.
- `fault_cause_o` out 2: 00 none, 01 bus error, 10 memory timeout, 11 MDU timeout.
- `instret_o` out 32: retired-instruction counter.

## Operation
- **States:** IDLE, MEM_REQ, MEM_WAIT, MDU_WAIT, COMMIT, FAULT.
- **IDLE → next state** when `issue_valid_i` is high:
  - `is_load_i` or `is_store_i` high → MEM_REQ. Latch address and wdata; set `mem_we_o` = `is_store_i`.
  - Else `is_mdu_i` high → MDU_WAIT. Pulse `mdu_start_o` for the acceptance cycle only (combinational on acceptance).
  - Else → COMMIT.
  - Load/store priority is higher than MDU if both flags are set.
  - The class flags and `rd_write_i` are latched for the whole instruction.
- **MEM_REQ:** `mem_req_o` = 1 with stable address, data and `mem_we_o`. On `mem_gnt_i` → MEM_WAIT, and `mem_req_o` drops the next cycle. `mem_rvalid_i` is ignored in MEM_REQ.
- **MEM_WAIT:** on `mem_rvalid_i`:
  - If `mem_err_i` is high → FAULT with cause 01.
  - Else → COMMIT. For a load, `memdatard_o` ← `mem_rdata_i`; a store leaves `memdatard_o` unchanged.
- **MDU_WAIT:** on `mdu_done_i` → COMMIT.
- **COMMIT:** lasts exactly one cycle, then → IDLE.
  - `pc_update_o` = 1.
  - `wb_en_o` = latched `rd_write_i`, forced to 0 for a store.
  - `instret_o` increments by 1 and wraps modulo 2^32.
- **Timeout counter:**
  - Cleared on entry to any wait state; increments each cycle spent in that state.
  - When it reaches `TIMEOUT_CYCLES` without the exit event → FAULT. Cause is 10 from MEM_REQ or MEM_WAIT, 11 from MDU_WAIT.
  - An exit event in the same cycle the count is reached wins over the timeout.
- **FAULT:** `fault_o` = 1 and the cause is held. The only exit is `flush_i` → IDLE, which clears the cause to 00.
- **Flush handling:**
  - `flush_i` in IDLE, MEM_REQ (before or without grant), MDU_WAIT or COMMIT → IDLE next cycle, with no commit. If the grant and flush arrive in the same cycle in MEM_REQ, the grant wins and the sequencer goes to MEM_WAIT with a pending flush.
  - `flush_i` in MEM_WAIT sets a pending-flush flag. When `mem_rvalid_i` arrives the sequencer → IDLE with no commit, no `memdatard_o` update and no fault, even if `mem_err_i` is high.
  - A pending flush does not stop the timeout; a timeout → FAULT and clears the flag.
  - A flush in IDLE that coincides with `issue_valid_i` blocks acceptance.
- `instret_o` is unaffected by flush and fault.

## Timing
- **Reset (asynchronous):**
  - State is IDLE.
  - All registered outputs are 0: `mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `memdatard_o`, `fault_cause_o`, `instret_o`.
  - Combinational outputs follow from the state: `issue_ready_o` = 1; `stall_o`, `mdu_start_o`, `wb_en_o`, `pc_update_o` and `fault_o` are 0.
  - Assertion mid-transaction abandons it immediately; any later bus response is ignored because the state is IDLE.
- **ALU or branch:** accepted in cycle N, COMMIT in N+1, ready again in N+2.
- **Load/store with grant in the first request cycle and rvalid one cycle after grant:** accept N, request N+1, rvalid N+2, COMMIT N+3.
- **MDU:** start at N, COMMIT the cycle after `mdu_done_i`.
- **Throughput:** at most 1 instruction per 2 cycles.

## Test plan
- ADD, `rd_write_i`=1, `issue_valid_i` at cycle 0 → `pc_update_o`=`wb_en_o`=1 at cycle 1, `instret_o`=1, `issue_ready_o`=1 at cycle 2.
- Load of address 0x100, grant after 3 request cycles, rvalid 2 cycles later with rdata 0xDEADBEEF → `mem_req_o` high for 3 cycles, `memdatard_o`=0xDEADBEEF at COMMIT, `wb_en_o`=1.
- Store of wdata 0x0000_00A5, grant immediately, rvalid with `mem_err_i`=1 → FAULT, `fault_cause_o`=01, no commit; `flush_i` → IDLE, cause back to 00.
- `TIMEOUT_CYCLES`=4, load with no grant → `fault_cause_o`=10 after 4 cycles in MEM_REQ. MDU op with no done → `fault_cause_o`=11.
- Flush in MEM_WAIT, rvalid 3 cycles later → IDLE, no `pc_update_o`, `memdatard_o` unchanged, `instret_o` unchanged.
- Reset asserted in MDU_WAIT → immediately `stall_o`=0, `issue_ready_o`=1, `instret_o`=0; a `mdu_done_i` after release causes no commit.

Source files
------------

// File: rtl/rv32im_exu_sequencer.sv
// Multi-cycle sequencer around the combinational EXU: memory handshake, MDU wait, one-cycle commit.
// Latency: ALU 2 cycles issue-to-ready; load/store and MDU add bus/MDU wait time. Backpressure: issue_ready_o only in IDLE.
module rv32im_exu_sequencer #(
  parameter int unsigned API_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      issue_valid_i,
  output logic                      issue_ready_o,
  input  logic                      is_load_i,
  input  logic                      is_store_i,
  input  logic                      is_mdu_i,
  input  logic                      rd_write_i,
  input  logic [API_DATA_WIDTH-1:0] exu_memaddr_i,
  input  logic [API_DATA_WIDTH-1:0] exu_memdatawr_i,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [API_DATA_WIDTH-1:0] mem_addr_o,
  output logic [API_DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                      mem_gnt_i,
  input  logic                      mem_rvalid_i,
  input  logic                      mem_err_i,
  input  logic [API_DATA_WIDTH-1:0] mem_rdata_i,
  output logic [API_DATA_WIDTH-1:0] memdatard_o,
  output logic                      mdu_start_o,
  input  logic                      mdu_done_i,
  output logic                      wb_en_o,
  output logic                      pc_update_o,
  output logic                      stall_o,
  input  logic                      flush_i,
  output logic                      fault_o,
  output logic [1:0]                fault_cause_o,
  output logic [31:0]               instret_o
);

  typedef enum logic [2:0] {
    IDLE, MEM_REQ, MEM_WAIT, MDU_WAIT, COMMIT, FAULT
  } state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_BUS_ERR = 2'b01;
  localparam logic [1:0] CAUSE_MEM_TMO = 2'b10;
  localparam logic [1:0] CAUSE_MDU_TMO = 2'b11;

  state_t      state, state_nxt;
  logic [15:0] tmo_cnt;
  logic        tmo_hit;
  logic        flush_pend, pend_eff;
  logic        is_load_q, is_store_q, rd_write_q;
  logic        accept, is_mem_op, load_capture;
  logic [1:0]  cause_nxt;

  assign is_mem_op = is_load_i | is_store_i;
  assign accept    = (state == IDLE) && issue_valid_i && !flush_i;
  // tmo_cnt counts from 0, so this marks the TIMEOUT_CYCLES-th cycle in a wait state
  assign tmo_hit   = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign pend_eff  = flush_pend | flush_i;

  always_comb begin
    state_nxt = state;
    cause_nxt = CAUSE_NONE;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_mem_op)     state_nxt = MEM_REQ;
          else if (is_mdu_i) state_nxt = MDU_WAIT;
          else               state_nxt = COMMIT;
        end
      end
      MEM_REQ: begin
        // a grant coinciding with flush still wins; the flush becomes pending
        if (mem_gnt_i)    state_nxt = MEM_WAIT;
        else if (flush_i) state_nxt = IDLE;
        else if (tmo_hit) begin
          state_nxt = FAULT;
          cause_nxt = CAUSE_MEM_TMO;
        end
      end
      MEM_WAIT: begin
        if (mem_rvalid_i) begin
          if (pend_eff)       state_nxt = IDLE;
          else if (mem_err_i) begin
            state_nxt = FAULT;
            cause_nxt = CAUSE_BUS_ERR;
          end else            state_nxt = COMMIT;
        end else if (tmo_hit) begin
          state_nxt = FAULT;
          cause_nxt = CAUSE_MEM_TMO;
        end
      end
      MDU_WAIT: begin
        if (flush_i)         state_nxt = IDLE;
        else if (mdu_done_i) state_nxt = COMMIT;
        else if (tmo_hit) begin
          state_nxt = FAULT;
          cause_nxt = CAUSE_MDU_TMO;
        end
      end
      COMMIT:  state_nxt = IDLE;
      FAULT:   if (flush_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign issue_ready_o = (state == IDLE);
  assign stall_o       = (state != IDLE);
  assign fault_o       = (state == FAULT);
  assign mdu_start_o   = accept && !is_mem_op && is_mdu_i;
  assign pc_update_o   = (state == COMMIT) && !flush_i;
  assign wb_en_o       = pc_update_o && rd_write_q && !is_store_q;
  assign load_capture  = (state == MEM_WAIT) && mem_rvalid_i && !pend_eff && !mem_err_i && is_load_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      tmo_cnt       <= '0;
      flush_pend    <= 1'b0;
      is_load_q     <= 1'b0;
      is_store_q    <= 1'b0;
      rd_write_q    <= 1'b0;
      mem_req_o     <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_wdata_o   <= '0;
      memdatard_o   <= '0;
      fault_cause_o <= CAUSE_NONE;
      instret_o     <= '0;
    end else begin
      state      <= state_nxt;
      mem_req_o  <= (state_nxt == MEM_REQ);
      flush_pend <= (state_nxt == MEM_WAIT) && pend_eff;
      tmo_cnt    <= (state_nxt != state) ? 16'd0 : tmo_cnt + 16'd1;
      if (accept) begin
        is_load_q  <= is_load_i;
        is_store_q <= is_store_i;
        rd_write_q <= rd_write_i;
      end
      if (accept && is_mem_op) begin
        mem_addr_o  <= exu_memaddr_i;
        mem_wdata_o <= exu_memdatawr_i;
        mem_we_o    <= is_store_i;
      end
      if (load_capture) memdatard_o <= mem_rdata_i;
      if (state != FAULT && state_nxt == FAULT) fault_cause_o <= cause_nxt;
      else if (state == FAULT && flush_i)       fault_cause_o <= CAUSE_NONE;
      if (pc_update_o) instret_o <= instret_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_rv32im_exu_sequencer.sv
// Directed bench for rv32im_exu_sequencer: stimulus pushes expected commits/faults, a monitor pops and compares.
module tb_rv32im_exu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 0, is_load = 0, is_store = 0, is_mdu = 0, rd_write = 0;
  logic [31:0] memaddr = 0, memdatawr = 0, mem_rdata = 0;
  logic        mem_gnt = 0, mem_rvalid = 0, mem_err = 0, mdu_done = 0, flush = 0;
  logic        issue_ready, mem_req, mem_we, mdu_start, wb_en, pc_update, stall, fault;
  logic [31:0] mem_addr, mem_wdata, memdatard, instret;
  logic [1:0]  fault_cause;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_fault;
    bit          wb;
    logic [31:0] rd;
    logic [31:0] ir;
    logic [1:0]  cause;
  } exp_t;
  exp_t exp_q[$];

  rv32im_exu_sequencer #(.API_DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .is_load_i(is_load), .is_store_i(is_store), .is_mdu_i(is_mdu), .rd_write_i(rd_write),
    .exu_memaddr_i(memaddr), .exu_memdatawr_i(memdatawr),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_err_i(mem_err), .mem_rdata_i(mem_rdata),
    .memdatard_o(memdatard), .mdu_start_o(mdu_start), .mdu_done_i(mdu_done),
    .wb_en_o(wb_en), .pc_update_o(pc_update), .stall_o(stall), .flush_i(flush),
    .fault_o(fault), .fault_cause_o(fault_cause), .instret_o(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_commit(input bit wb, input logic [31:0] rd, input logic [31:0] ir);
    exp_t e;
    e.is_fault = 0; e.wb = wb; e.rd = rd; e.ir = ir; e.cause = 2'b00;
    exp_q.push_back(e);
  endtask

  task automatic push_fault(input logic [1:0] cause, input logic [31:0] ir);
    exp_t e;
    e.is_fault = 1; e.wb = 0; e.rd = 0; e.ir = ir; e.cause = cause;
    exp_q.push_back(e);
  endtask

  task automatic issue(input bit ld, input bit st, input bit md, input bit rdw,
                       input logic [31:0] addr, input logic [31:0] wd);
    issue_valid = 1; is_load = ld; is_store = st; is_mdu = md; rd_write = rdw;
    memaddr = addr; memdatawr = wd;
    #1;
    chk("issue_ready_at_issue", 32'(issue_ready), 32'd1);
    chk("mdu_start_at_issue", 32'(mdu_start), 32'(md && !ld && !st));
    tick();
    issue_valid = 0; is_load = 0; is_store = 0; is_mdu = 0; rd_write = 0;
  endtask

  task automatic flush_cycle();
    flush = 1;
    tick();
    flush = 0;
  endtask

  // Monitor: every commit strobe and every entry into FAULT must match the next expectation.
  logic fault_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (pc_update) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_commit: got pc_update=1 expected no commit");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("commit_kind", 32'(0), 32'(e.is_fault));
          chk("commit_wb_en", 32'(wb_en), 32'(e.wb));
          chk("commit_memdatard", memdatard, e.rd);
          chk("commit_instret", instret, e.ir);
        end
      end
      if (fault && !fault_prev) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_fault: got cause %0d expected no fault", fault_cause);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("fault_kind", 32'(1), 32'(e.is_fault));
          chk("fault_cause", 32'(fault_cause), 32'(e.cause));
          chk("fault_instret", instret, e.ir);
        end
      end
    end
    fault_prev <= fault && !rst;
  end

  initial begin
    #2;
    chk("rst_ready", 32'(issue_ready), 32'd1);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_strobes", {28'd0, mdu_start, wb_en, pc_update, fault}, 32'd0);
    chk("rst_mem_req_we", {30'd0, mem_req, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_memdatard", memdatard, 32'd0);
    chk("rst_cause", 32'(fault_cause), 32'd0);
    chk("rst_instret", instret, 32'd0);
    tick();
    rst = 0;
    tick();

    // ADD: commit at N+1, ready at N+2
    push_commit(1, 32'h0, 32'd0);
    issue(0, 0, 0, 1, 32'h0, 32'h0);
    chk("add_commit_stall", 32'(stall), 32'd1);
    chk("add_commit_pc_update", 32'(pc_update), 32'd1);
    tick();
    chk("add_ready_n2", 32'(issue_ready), 32'd1);
    chk("add_instret", instret, 32'd1);

    // Load 0x100, grant on the 3rd request cycle, rvalid two cycles after grant
    push_commit(1, 32'hDEADBEEF, 32'd1);
    issue(1, 0, 0, 1, 32'h100, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("load_mem_req_high", 32'(mem_req), 32'd1);
      chk("load_mem_addr", mem_addr, 32'h100);
      if (i == 2) mem_gnt = 1;
      tick();
    end
    mem_gnt = 0;
    chk("load_mem_req_dropped", 32'(mem_req), 32'd0);
    mem_rvalid = 1; mem_rdata = 32'h0BAD_0BAD;
    chk("load_rvalid_early_ignored_state", 32'(stall), 32'd1);
    mem_rvalid = 0;
    tick();
    mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_rvalid = 0;
    chk("load_commit_memdatard", memdatard, 32'hDEADBEEF);
    tick();

    // Store that completes: write-back suppressed, load data untouched
    push_commit(0, 32'hDEADBEEF, 32'd2);
    issue(0, 1, 0, 1, 32'h200, 32'h0000_00A5);
    chk("store_we", 32'(mem_we), 32'd1);
    chk("store_wdata", mem_wdata, 32'h0000_00A5);
    mem_gnt = 1;
    tick();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_rvalid = 0;
    tick();

    // Store with bus error -> FAULT 01, held until flush
    push_fault(2'b01, 32'd3);
    issue(0, 1, 0, 1, 32'h204, 32'h0000_00A5);
    mem_gnt = 1;
    tick();
    mem_gnt = 0; mem_rvalid = 1; mem_err = 1;
    tick();
    mem_rvalid = 0; mem_err = 0;
    chk("buserr_fault", 32'(fault), 32'd1);
    tick();
    chk("buserr_cause_held", 32'(fault_cause), 32'd1);
    flush_cycle();
    chk("buserr_flush_fault_clear", 32'(fault), 32'd0);
    chk("buserr_flush_cause_clear", 32'(fault_cause), 32'd0);
    chk("buserr_flush_ready", 32'(issue_ready), 32'd1);

    // Load with no grant -> FAULT 10 after 4 request cycles
    push_fault(2'b10, 32'd3);
    issue(1, 0, 0, 1, 32'h400, 32'h0);
    repeat (3) tick();
    chk("memtmo_still_req", 32'(mem_req), 32'd1);
    chk("memtmo_no_fault_yet", 32'(fault), 32'd0);
    tick();
    chk("memtmo_cause", 32'(fault_cause), 32'd2);
    flush_cycle();

    // MDU with no done -> FAULT 11
    push_fault(2'b11, 32'd3);
    issue(0, 0, 1, 1, 32'h0, 32'h0);
    chk("mdu_start_one_cycle", 32'(mdu_start), 32'd0);
    repeat (3) tick();
    chk("mdutmo_no_fault_yet", 32'(fault), 32'd0);
    tick();
    chk("mdutmo_cause", 32'(fault_cause), 32'd3);
    flush_cycle();

    // MDU completing normally: commit the cycle after done
    push_commit(1, 32'hDEADBEEF, 32'd3);
    issue(0, 0, 1, 1, 32'h0, 32'h0);
    tick();
    mdu_done = 1;
    tick();
    mdu_done = 0;
    chk("mdu_commit_strobe", 32'(pc_update), 32'd1);
    tick();
    chk("mdu_instret", instret, 32'd4);

    // Flush in MEM_WAIT, erroring rvalid 3 cycles later -> silent return to IDLE
    issue(1, 0, 0, 1, 32'h300, 32'h0);
    mem_gnt = 1;
    tick();
    mem_gnt = 0; flush = 1;
    tick();
    flush = 0;
    chk("pendflush_waits_for_rvalid", 32'(stall), 32'd1);
    tick();
    tick();
    mem_rvalid = 1; mem_err = 1; mem_rdata = 32'h1234_5678;
    tick();
    mem_rvalid = 0; mem_err = 0;
    chk("pendflush_idle", 32'(issue_ready), 32'd1);
    chk("pendflush_no_fault", 32'(fault), 32'd0);
    chk("pendflush_memdatard", memdatard, 32'hDEADBEEF);
    chk("pendflush_instret", instret, 32'd4);
    tick();

    // Reset asserted in MDU_WAIT; a later done must not commit
    issue(0, 0, 1, 1, 32'h0, 32'h0);
    tick();
    #2 rst = 1;
    #1;
    chk("rst_mdu_stall", 32'(stall), 32'd0);
    chk("rst_mdu_ready", 32'(issue_ready), 32'd1);
    chk("rst_mdu_instret", instret, 32'd0);
    tick();
    #2 rst = 0;
    tick();
    mdu_done = 1;
    tick();
    mdu_done = 0;
    tick();
    chk("rst_mdu_no_commit_instret", instret, 32'd0);
    chk("rst_mdu_no_commit_ready", 32'(issue_ready), 32'd1);

    repeat (3) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
